// File: rtl/shift_sequencer.sv
// ---------------------------------------------------------------------------
// shift_sequencer
//   Command-driven controller for an 8-bit mode-controlled shift register.
//   Accepts clear / load / shift-left / shift-right commands over a
//   valid/ready handshake and drives the register's mode/data_in pins one
//   cycle at a time. A shadow copy of the register contents is kept so the
//   register can be held (reloaded from shadow) while idle, since the
//   register itself has no hold mode.
//
// Ports
//   clk        rising-edge clock shared with the shift register
//   rst        synchronous, active-high reset
//   cmd_valid  command present
//   cmd_ready  command can be accepted this cycle
//   cmd_op     00 clear, 01 load, 10 shift left, 11 shift right
//   cmd_cnt    shift count minus one (ignored for clear/load)
//   cmd_data   load value (ignored for clear/shift)
//   mode       to register mode input (00 clr, 01 load, 10 shl, 11 shr)
//   data_in    to register parallel input
//   busy       command executing
//   done       one-cycle pulse after a command completes
//   shadow     mirror of the register contents
// ---------------------------------------------------------------------------
module shift_sequencer #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [CNT_W-1:0] cmd_cnt,
   input  logic [WIDTH-1:0] cmd_data,
   output logic [1:0]       mode,
   output logic [WIDTH-1:0] data_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] shadow
);

   typedef enum logic {
      S_IDLE,
      S_EXEC
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [1:0]         r_op;
   logic [1:0]         w_op_nxt;
   logic [WIDTH-1:0]   r_data;
   logic [WIDTH-1:0]   w_data_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic               r_done;
   logic               w_done_nxt;
   logic [WIDTH-1:0]   r_shadow;
   logic [WIDTH-1:0]   w_shadow_nxt;
   logic [1:0]         w_mode;
   logic [WIDTH-1:0]   w_data_in;
   logic               w_ready;
   logic               w_busy;

   // Next-state, latched fields and register pin drive.
   always_comb begin
      w_state_nxt = r_state;
      w_op_nxt    = r_op;
      w_data_nxt  = r_data;
      w_cnt_nxt   = r_cnt;
      w_done_nxt  = 1'b0;
      w_mode      = 2'b01;      // idle: hold register by reloading shadow
      w_data_in   = r_shadow;
      w_ready     = 1'b0;
      w_busy      = 1'b0;

      case (r_state)
         S_IDLE: begin
            w_ready = 1'b1;
            if (cmd_valid) begin
               w_op_nxt    = cmd_op;
               w_data_nxt  = cmd_data;
               // clear/load always take a single cycle
               w_cnt_nxt   = cmd_op[1] ? cmd_cnt : '0;
               w_state_nxt = S_EXEC;
            end
         end
         S_EXEC: begin
            w_busy = 1'b1;
            w_mode = r_op;
            if (r_op == 2'b01) begin
               w_data_in = r_data;
            end
            if (r_cnt != '0) begin
               w_cnt_nxt = r_cnt - 1'b1;
            end else begin
               w_state_nxt = S_IDLE;
               w_done_nxt  = 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      // Reset forces a clear on the register in the same edge as ours.
      if (rst) begin
         w_mode  = 2'b00;
         w_ready = 1'b0;
      end

      // Shadow follows exactly what the register does with the pins we drive.
      case (w_mode)
         2'b00:   w_shadow_nxt = '0;
         2'b01:   w_shadow_nxt = w_data_in;
         2'b10:   w_shadow_nxt = {r_shadow[WIDTH-2:0], 1'b0};
         default: w_shadow_nxt = {1'b0, r_shadow[WIDTH-1:1]};
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_op     <= '0;
         r_data   <= '0;
         r_cnt    <= '0;
         r_done   <= 1'b0;
         r_shadow <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_op     <= w_op_nxt;
         r_data   <= w_data_nxt;
         r_cnt    <= w_cnt_nxt;
         r_done   <= w_done_nxt;
         r_shadow <= w_shadow_nxt;
      end
   end

   assign cmd_ready = w_ready;
   assign busy      = w_busy;
   assign done      = r_done;
   assign mode      = w_mode;
   assign data_in   = w_data_in;
   assign shadow    = r_shadow;

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [1:0] cmd_op = 2'b00;
   logic [2:0] cmd_cnt = 3'd0;
   logic [7:0] cmd_data = 8'h00;
   logic [1:0] mode;
   logic [7:0] data_in;
   logic       busy;
   logic       done;
   logic [7:0] shadow;

   shift_sequencer #(.WIDTH(8), .CNT_W(3)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_cnt(cmd_cnt), .cmd_data(cmd_data),
      .mode(mode), .data_in(data_in), .busy(busy), .done(done),
      .shadow(shadow)
   );

   always #5 clk = ~clk;

   // Downstream mode-controlled shift register, preloaded with 0xFF.
   logic [7:0] reg_q = 8'hFF;
   always @(posedge clk) begin
      case (mode)
         2'b00:   reg_q <= 8'h00;
         2'b01:   reg_q <= data_in;
         2'b10:   reg_q <= {reg_q[6:0], 1'b0};
         default: reg_q <= {1'b0, reg_q[7:1]};
      endcase
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   typedef struct {
      int val;
      int lat;
      int hs;
   } exp_t;
   exp_t sb[$];

   int cur = 0;          // register value implied by all accepted commands
   int last_hs = -1;

   // Monitor: per-cycle invariants and completion scoreboard.
   always @(negedge clk) begin
      if (cyc > 0) begin
         chk("shadow_vs_reg", shadow, reg_q);
         if (rst) begin
            chk("rst_mode", mode, 0);
            chk("rst_ready", cmd_ready, 0);
         end
         if (done) begin
            if (sb.size() == 0) begin
               chk("spurious_done", 1, 0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("result_shadow", shadow, e.val);
               chk("result_reg", reg_q, e.val);
               chk("latency", cyc - e.hs, e.lat);
            end
         end
      end
   end

   // Present a command (valid left high afterwards) and record expectations
   // at the accepting edge. exp_gap < 0 disables the spacing check.
   task automatic send(input int op, input int cnt, input int data, input int exp_gap);
      int w;
      int n;
      exp_t e;
      cmd_op    = 2'(op);
      cmd_cnt   = 3'(cnt);
      cmd_data  = 8'(data);
      cmd_valid = 1'b1;
      w = 0;
      forever begin
         @(negedge clk);
         if (cmd_ready) break;
         w++;
         if (w > 40) begin
            chk("ready_timeout", 0, 1);
            cmd_valid = 1'b0;
            return;
         end
      end
      @(posedge clk);
      #1;
      n = (op >= 2) ? cnt + 1 : 1;
      case (op)
         0:       cur = 0;
         1:       cur = data & 255;
         2:       cur = (cur << n) & 255;
         default: cur = cur >> n;
      endcase
      e.val = cur;
      e.lat = n;
      e.hs  = cyc;
      sb.push_back(e);
      if (exp_gap >= 0 && last_hs >= 0) chk("accept_gap", cyc - last_hs, exp_gap);
      last_hs = cyc;
   endtask

   task automatic idle(input int n);
      cmd_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain();
      int w;
      cmd_valid = 1'b0;
      w = 0;
      while (sb.size() != 0 && w < 40) begin
         @(posedge clk);
         #1;
         w++;
      end
      chk("drain", sb.size(), 0);
   endtask

   initial begin
      // Reset for two cycles with the register preloaded.
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_reg", reg_q, 0);
      chk("rst_shadow", shadow, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", cmd_ready, 1);
      chk("idle_mode", mode, 1);
      @(posedge clk);
      #1;

      // Load and hold.
      send(1, 5, 8'hA5, -1);
      drain();
      idle(10);
      chk("hold_reg", reg_q, 8'hA5);

      // Left shift by 3.
      send(2, 2, 0, -1);
      drain();
      chk("shl3_reg", reg_q, 8'h28);

      // Full right shift; a held different op waits for completion.
      send(1, 0, 8'hFF, -1);
      drain();
      send(3, 7, 0, -1);
      send(1, 0, 8'h5A, 9);
      drain();
      chk("load_after_shr", reg_q, 8'h5A);

      // Reset mid-operation on the third EXEC cycle.
      send(1, 0, 8'h81, -1);
      drain();
      send(2, 7, 0, -1);
      cmd_valid = 1'b0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      chk("midop_busy", busy, 1);
      rst = 1'b1;
      sb.delete();
      cur = 0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("midop_reg", reg_q, 0);
      chk("midop_shadow", shadow, 0);
      chk("midop_busy_after", busy, 0);
      chk("midop_done", done, 0);
      chk("midop_ready", cmd_ready, 1);
      idle(3);

      // Back-to-back with valid always high.
      last_hs = -1;
      send(0, 3, 8'hEE, -1);
      send(1, 6, 8'h3C, 2);
      send(3, 1, 8'h77, 2);
      send(2, 0, 8'h11, 3);
      drain();
      chk("b2b_reg", reg_q, 8'h1E);

      // Randomized commands with random spacing.
      for (int i = 0; i < 60; i++) begin
         send(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
              int'($urandom_range(0, 255)), -1);
         if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(0, 4)));
      end
      drain();
      chk("final_reg", reg_q, cur);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=%0d expected=finish", cyc);
      $fatal(1, "timeout");
   end

endmodule
